// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit skid FIFOs feeding a round-robin scheduler
// that drives one registered common-data-bus broadcast per cycle.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_REQ-1:0]        cdb_src
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BCAST} state_e;

  logic [TAG_W-1:0]  tmem_q [NUM_REQ][FIFO_DEPTH];
  logic [TAG_W-1:0]  tmem_d [NUM_REQ][FIFO_DEPTH];
  logic [DATA_W-1:0] dmem_q [NUM_REQ][FIFO_DEPTH];
  logic [DATA_W-1:0] dmem_d [NUM_REQ][FIFO_DEPTH];
  logic [CW-1:0]     cnt_q  [NUM_REQ];
  logic [CW-1:0]     cnt_d  [NUM_REQ];
  logic [PW-1:0]     wp_q   [NUM_REQ];
  logic [PW-1:0]     wp_d   [NUM_REQ];
  logic [PW-1:0]     rp_q   [NUM_REQ];
  logic [PW-1:0]     rp_d   [NUM_REQ];

  logic [RW-1:0]      rr_q, rr_d;
  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] src_q, src_d;

  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] enq;
  logic [NUM_REQ-1:0] pop;
  logic               found;
  logic               grant;
  logic [RW-1:0]      win;

  function automatic logic [RW-1:0] rr_idx(
    input logic [RW-1:0] base,
    input int            k
  );
    int j;
    j = int'(base) + k;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return RW'(j);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at registered occupancy: no full-FIFO bypass.
  always_comb begin
    nonempty  = '0;
    req_ready = '0;
    enq       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty[i]  = (cnt_q[i] != '0);
      req_ready[i] = en & (cnt_q[i] != CW'(FIFO_DEPTH));
    end
    push = req_valid & req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      enq[i] = push[i] & req_tag[i*TAG_W + TAG_W - 1];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && nonempty[rr_idx(rr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_q, k);
      end
    end
    grant = en & found;
    pop   = grant ? (NUM_REQ'(1) << win) : '0;
  end

  always_comb begin
    tmem_d = tmem_q;
    dmem_d = dmem_q;
    cnt_d  = cnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enq[i]) begin
        tmem_d[i][wp_q[i]] = req_tag[i*TAG_W +: TAG_W];
        dmem_d[i][wp_q[i]] = req_data[i*DATA_W +: DATA_W];
        wp_d[i]            = ptr_inc(wp_q[i]);
      end
      if (pop[i]) rp_d[i] = ptr_inc(rp_q[i]);
      cnt_d[i] = cnt_q[i] + CW'(enq[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = '0;
    unique case (state_q)
      IDLE:    if (grant)  state_d = BCAST;
      BCAST:   if (!grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant) begin
      tag_d  = tmem_q[win][rp_q[win]];
      data_d = dmem_q[win][rp_q[win]];
      src_d  = pop;
      rr_d   = rr_idx(win, 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    tmem_q <= tmem_d;
    dmem_q <= dmem_d;
  end

  assign cdb_valid = (state_q == BCAST);
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven vectors plus reset sequences,
// expected broadcasts queued on drive and popped after each edge.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [3:0]   req_valid;
  logic [31:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         cdb_valid;
  logic [7:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [3:0]   cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ(4), .DATA_W(32), .TAG_W(8), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  typedef struct {
    logic         en;
    logic [3:0]   vld;
    logic [31:0]  tg;
    logic [127:0] dt;
    logic [3:0]   rdy;
    logic         v;
    logic [3:0]   src;
    logic [7:0]   t;
    logic [31:0]  d;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] src;
    logic [7:0] t;
    logic [31:0] d;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  function automatic vec_t mk(
    input logic en, input logic [3:0] vld,
    input logic [31:0] tg, input logic [127:0] dt,
    input logic [3:0] rdy, input logic v,
    input logic [3:0] src, input logic [7:0] t,
    input logic [31:0] d);
    vec_t r;
    r.en = en; r.vld = vld; r.tg = tg; r.dt = dt;
    r.rdy = rdy; r.v = v; r.src = src; r.t = t; r.d = d;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] v,
                       input logic [31:0] t,
                       input logic [127:0] d);
    en = e; req_valid = v; req_tag = t; req_data = d;
  endtask

  task automatic tick(input string nm, input logic v,
                      input logic [3:0] s, input logic [7:0] t,
                      input logic [31:0] d);
    exp_t e;
    e.v = v; e.src = s; e.t = t; e.d = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(nm, {19'd0, cdb_valid, cdb_src, cdb_tag, cdb_data},
            {19'd0, e.v, e.src, e.t, e.d});
  endtask

  initial begin
    // contention from rr=0, then 0+3 pair
    tbl.push_back(mk(1,4'b0000,32'h0,128'h0,4'hF,0,4'b0000,8'h00,32'h0));
    tbl.push_back(mk(1,4'b1111,{8'h83,8'h82,8'h81,8'h80},
      {32'h10000003,32'h10000002,32'h10000001,32'h10000000},
      4'hF,0,4'b0000,8'h00,32'h0));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0001,8'h80,32'h10000000));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0010,8'h81,32'h10000001));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0100,8'h82,32'h10000002));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b1000,8'h83,32'h10000003));
    tbl.push_back(mk(1,0,0,0,4'hF,0,4'b0000,8'h83,32'h10000003));
    tbl.push_back(mk(1,4'b1001,{8'h85,16'h0,8'h84},
      {32'h20000003,64'h0,32'h20000000},
      4'hF,0,4'b0000,8'h83,32'h10000003));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0001,8'h84,32'h20000000));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b1000,8'h85,32'h20000003));
    tbl.push_back(mk(1,0,0,0,4'hF,0,4'b0000,8'h85,32'h20000003));
    // single result with one-cycle latency
    tbl.push_back(mk(1,4'b0010,{16'h0,8'h82,8'h0},
      {64'h0,32'hDEADBEEF,32'h0},4'hF,0,4'b0000,8'h85,32'h20000003));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0010,8'h82,32'hDEADBEEF));
    tbl.push_back(mk(1,0,0,0,4'hF,0,4'b0000,8'h82,32'hDEADBEEF));
    // null tag on unit 3
    tbl.push_back(mk(1,4'b1000,{8'h05,24'h0},{32'h12345678,96'h0},
      4'hF,0,4'b0000,8'h82,32'hDEADBEEF));
    tbl.push_back(mk(1,0,0,0,4'hF,0,4'b0000,8'h82,32'hDEADBEEF));
    // enable freeze with two queued entries, rr=2
    tbl.push_back(mk(1,4'b0011,{16'h0,8'h87,8'h86},
      {64'h0,32'h30000001,32'h30000000},
      4'hF,0,4'b0000,8'h82,32'hDEADBEEF));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,4'b0011,{16'h0,8'h87,8'h86},
        {64'h0,32'h30000001,32'h30000000},
        4'h0,0,4'b0000,8'h82,32'hDEADBEEF));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0001,8'h86,32'h30000000));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0010,8'h87,32'h30000001));
    tbl.push_back(mk(1,0,0,0,4'hF,0,4'b0000,8'h87,32'h30000001));
    tbl.push_back(mk(1,4'b1000,{8'h88,24'h0},{32'h40000003,96'h0},
      4'hF,0,4'b0000,8'h87,32'h30000001));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b1000,8'h88,32'h40000003));
    // backpressure: unit 0 floods, unit 2 holds valid
    tbl.push_back(mk(1,4'b0101,{8'h0,8'hA0,8'h0,8'h90},
      {32'h0,32'hB0000000,32'h0,32'hA0000000},
      4'hF,0,4'b0000,8'h88,32'h40000003));
    tbl.push_back(mk(1,4'b0101,{8'h0,8'hA1,8'h0,8'h91},
      {32'h0,32'hB0000001,32'h0,32'hA0000001},
      4'hF,1,4'b0001,8'h90,32'hA0000000));
    tbl.push_back(mk(1,4'b0101,{8'h0,8'hA2,8'h0,8'h92},
      {32'h0,32'hB0000002,32'h0,32'hA0000002},
      4'b1011,1,4'b0100,8'hA0,32'hB0000000));
    tbl.push_back(mk(1,4'b0101,{8'h0,8'hA2,8'h0,8'h93},
      {32'h0,32'hB0000002,32'h0,32'hA0000003},
      4'b1110,1,4'b0001,8'h91,32'hA0000001));
    tbl.push_back(mk(1,4'b0101,{8'h0,8'hA3,8'h0,8'h93},
      {32'h0,32'hB0000003,32'h0,32'hA0000003},
      4'b1011,1,4'b0100,8'hA1,32'hB0000001));
    tbl.push_back(mk(1,0,0,0,4'b1110,1,4'b0001,8'h92,32'hA0000002));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0100,8'hA2,32'hB0000002));
    tbl.push_back(mk(1,0,0,0,4'hF,1,4'b0001,8'h93,32'hA0000003));
    tbl.push_back(mk(1,0,0,0,4'hF,0,4'b0000,8'h93,32'hA0000003));

    reset = 1'b1;
    drive(1, 4'b0, 32'h0, 128'h0);
    #2 reset = 1'b0;
    #1;
    chk("init_out", {19'd0, cdb_valid, cdb_src, cdb_tag, cdb_data}, 64'd0);
    chk("init_rdy", 64'(req_ready), 64'hF);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].vld, tbl[i].tg, tbl[i].dt);
      #1;
      chk($sformatf("rdy%0d", i), 64'(req_ready), 64'(tbl[i].rdy));
      tick($sformatf("cdb%0d", i), tbl[i].v, tbl[i].src,
           tbl[i].t, tbl[i].d);
    end

    // asynchronous reset mid-operation, rr=1 before it
    drive(1, 4'b0110, {8'h0, 8'hC2, 8'hC1, 8'h0},
          {32'h0, 32'hC2000000, 32'hC1000000, 32'h0});
    tick("rs_push", 0, 4'b0000, 8'h93, 32'hA0000003);
    drive(1, 4'b0, 32'h0, 128'h0);
    tick("rs_g1", 1, 4'b0010, 8'hC1, 32'hC1000000);
    #3;
    reset = 1'b0;
    drive(1, 4'b0001, {24'h0, 8'hD0}, {96'h0, 32'hD0000000});
    #1;
    chk("rs_async", {19'd0, cdb_valid, cdb_src, cdb_tag, cdb_data}, 64'd0);
    chk("rs_rdy", 64'(req_ready), 64'hF);
    tick("rs_hold", 0, 4'b0000, 8'h00, 32'h0);
    reset = 1'b1;
    drive(1, 4'b0011, {16'h0, 8'hE1, 8'hE0},
          {64'h0, 32'hE1000000, 32'hE0000000});
    tick("rs_push2", 0, 4'b0000, 8'h00, 32'h0);
    drive(1, 4'b0, 32'h0, 128'h0);
    tick("rs_first", 1, 4'b0001, 8'hE0, 32'hE0000000);
    tick("rs_second", 1, 4'b0010, 8'hE1, 32'hE1000000);
    tick("rs_drain", 0, 4'b0000, 8'hE1, 32'hE1000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
